// File: rtl/vector_reg_file_ls_if.sv
// Bus interface for the vector register file: read ports, direct write port
// and the lane-serial load stream.
interface vector_reg_file_ls_if #(
  parameter int ADDR_W = 3,
  parameter int LANES  = 16,
  parameter int LANE_W = 16
);
  localparam int VEC_W = LANES * LANE_W;

  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [VEC_W-1:0]  data_1;
  logic [VEC_W-1:0]  data_2;
  logic              busy_1;
  logic              busy_2;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_dst;
  logic [VEC_W-1:0]  wr_data;
  logic [LANES-1:0]  wr_mask;

  logic              ld_start;
  logic [ADDR_W-1:0] ld_dst;
  logic              ld_abort;
  logic              ld_valid;
  logic [LANE_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              wr_conflict;

  modport master (
    output rd_addr_1, rd_addr_2, wr_en, wr_dst, wr_data, wr_mask,
           ld_start, ld_dst, ld_abort, ld_valid, ld_data,
    input  data_1, data_2, busy_1, busy_2, ld_ready, ld_done, wr_conflict
  );

  modport slave (
    input  rd_addr_1, rd_addr_2, wr_en, wr_dst, wr_data, wr_mask,
           ld_start, ld_dst, ld_abort, ld_valid, ld_data,
    output data_1, data_2, busy_1, busy_2, ld_ready, ld_done, wr_conflict
  );
endinterface

// File: rtl/vector_reg_file_ls.sv
// Vector register file with two bypassed read ports, a masked direct write
// port and a lane-serial load port that stages a full vector and commits it
// atomically. A per-register busy bit marks registers with a load in flight.
//
// state  | meaning
// IDLE   | no load in flight, waiting for ld_start
// FILL   | accepting lanes into the staging buffer (ld_ready high)
// COMMIT | staging buffer written to the target register (ld_done high)
module vector_reg_file_ls #(
  parameter int NUM_REGS = 8,
  parameter int LANES    = 16,
  parameter int LANE_W   = 16,
  parameter int ADDR_W   = 3
) (
  input logic               clk,
  input logic               rst,
  vector_reg_file_ls_if.slave bus
);
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   dst;
  vec_t                staging;
  logic [NUM_REGS-1:0] busy;
  logic                ld_ready_q;
  logic                ld_done_q;
  logic                wr_conflict_q;
  vec_t                regs [NUM_REGS];
  vec_t                wr_lanes;
  vec_t                rd_1;
  vec_t                rd_2;
  logic                wr_hit;

  // Non-power-of-2 register counts leave addresses with no register behind them.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // Overlay masked lanes of a same-cycle direct write onto the stored value.
  function automatic vec_t bypass(input vec_t stored, input logic [ADDR_W-1:0] addr,
                                  input logic hit, input logic [ADDR_W-1:0] wdst,
                                  input logic [LANES-1:0] mask, input vec_t wl);
    vec_t v;
    v = stored;
    if (hit && (wdst == addr)) begin
      for (int l = 0; l < LANES; l++) begin
        if (mask[l]) v[l] = wl[l];
      end
    end
    return v;
  endfunction

  assign wr_lanes = bus.wr_data;
  assign wr_hit   = bus.wr_en && in_range(bus.wr_dst);

  // Combinational read ports with direct-write bypass; commits are not bypassed.
  always_comb begin
    rd_1 = '0;
    rd_2 = '0;
    if (in_range(bus.rd_addr_1)) rd_1 = regs[bus.rd_addr_1];
    if (in_range(bus.rd_addr_2)) rd_2 = regs[bus.rd_addr_2];
    rd_1 = bypass(rd_1, bus.rd_addr_1, wr_hit, bus.wr_dst, bus.wr_mask, wr_lanes);
    rd_2 = bypass(rd_2, bus.rd_addr_2, wr_hit, bus.wr_dst, bus.wr_mask, wr_lanes);
  end

  assign bus.data_1      = rd_1;
  assign bus.data_2      = rd_2;
  assign bus.busy_1      = in_range(bus.rd_addr_1) && busy[bus.rd_addr_1];
  assign bus.busy_2      = in_range(bus.rd_addr_2) && busy[bus.rd_addr_2];
  assign bus.ld_ready    = ld_ready_q;
  assign bus.ld_done     = ld_done_q;
  assign bus.wr_conflict = wr_conflict_q;

  // Loader FSM: staging fill, busy scoreboard and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dst        <= '0;
      staging    <= '0;
      busy       <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ld_start) begin
            dst        <= bus.ld_dst;
            cnt        <= '0;
            if (in_range(bus.ld_dst)) busy[bus.ld_dst] <= 1'b1;
            state      <= FILL;
            ld_ready_q <= 1'b1;
          end
        end
        FILL: begin
          if (bus.ld_abort) begin
            if (in_range(dst)) busy[dst] <= 1'b0;
            state      <= IDLE;
            ld_ready_q <= 1'b0;
          end else if (bus.ld_valid) begin
            staging[cnt] <= bus.ld_data;
            cnt          <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(LANES - 1)) begin
              state      <= COMMIT;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
            end
          end
        end
        COMMIT: begin
          // Abort here only suppresses the register write in the storage block.
          if (in_range(dst)) busy[dst] <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          ld_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Flag a direct write that lands on a register with a load in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_conflict_q <= 1'b0;
    else     wr_conflict_q <= wr_hit && busy[bus.wr_dst];
  end

  // Register storage: masked direct write, then the commit so the loader wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      if (wr_hit) begin
        for (int l = 0; l < LANES; l++) begin
          if (bus.wr_mask[l]) regs[bus.wr_dst][l] <= wr_lanes[l];
        end
      end
      if ((state == COMMIT) && !bus.ld_abort && in_range(dst)) regs[dst] <= staging;
    end
  end
endmodule

// File: tb/tb_vector_reg_file_ls.sv
// Self-checking bench for vector_reg_file_ls: directed scenarios followed by
// random traffic, all compared against a lane-level reference model.
module tb_vector_reg_file_ls;
  localparam int NR = 8;
  localparam int L  = 16;
  localparam int LW = 16;
  localparam int AW = 3;
  localparam int VW = L * LW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_reg_file_ls_if #(.ADDR_W(AW), .LANES(L), .LANE_W(LW)) bus ();

  vector_reg_file_ls #(.NUM_REGS(NR), .LANES(L), .LANE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Reference model: register contents per lane, busy flags, load progress.
  logic [LW-1:0] m [NR][L];
  bit            mbusy [NR];
  bit            act;
  bit            cpend;
  int            mdst;
  logic [LW-1:0] q [$];
  bit            wconf;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int r = 0; r < NR; r++) begin
      mbusy[r] = 0;
      for (int l = 0; l < L; l++) m[r][l] = '0;
    end
    act = 0; cpend = 0; wconf = 0; mdst = 0;
    q.delete();
  endtask

  function automatic logic [VW-1:0] exp_read(input logic [AW-1:0] a);
    logic [VW-1:0] v;
    for (int l = 0; l < L; l++) begin
      if (bus.wr_en && bus.wr_dst == a && bus.wr_mask[l]) v[l*LW +: LW] = bus.wr_data[l*LW +: LW];
      else v[l*LW +: LW] = m[a][l];
    end
    return v;
  endfunction

  task automatic check_outs();
    chk("data_1", bus.data_1, exp_read(bus.rd_addr_1));
    chk("data_2", bus.data_2, exp_read(bus.rd_addr_2));
    chk("busy_1", bus.busy_1, mbusy[bus.rd_addr_1]);
    chk("busy_2", bus.busy_2, mbusy[bus.rd_addr_2]);
    chk("ld_ready", bus.ld_ready, act && !cpend);
    chk("ld_done", bus.ld_done, cpend);
    chk("wr_conflict", bus.wr_conflict, wconf);
  endtask

  // Apply the rules for one clock edge to the model using the current inputs.
  task automatic update_model();
    bit wnext;
    wnext = bus.wr_en && mbusy[bus.wr_dst];
    if (bus.wr_en)
      for (int l = 0; l < L; l++)
        if (bus.wr_mask[l]) m[bus.wr_dst][l] = bus.wr_data[l*LW +: LW];
    if (cpend) begin
      if (!bus.ld_abort) for (int l = 0; l < L; l++) m[mdst][l] = q[l];
      mbusy[mdst] = 0; cpend = 0; act = 0;
    end else if (act) begin
      if (bus.ld_abort) begin
        mbusy[mdst] = 0; act = 0; q.delete();
      end else if (bus.ld_valid) begin
        q.push_back(bus.ld_data);
        if (q.size() == L) cpend = 1;
      end
    end else if (bus.ld_start) begin
      act = 1; mdst = int'(bus.ld_dst); mbusy[mdst] = 1; q.delete();
    end
    wconf = wnext;
  endtask

  task automatic cyc();
    #1;
    check_outs();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0; bus.wr_dst = '0; bus.wr_data = '0; bus.wr_mask = '0;
    bus.ld_start = 0; bus.ld_dst = '0; bus.ld_abort = 0; bus.ld_valid = 0; bus.ld_data = '0;
  endtask

  task automatic start_load(input int d);
    bus.ld_start = 1; bus.ld_dst = AW'(d);
    cyc();
    bus.ld_start = 0;
  endtask

  task automatic beats(input int base, input int n);
    for (int b = 0; b < n; b++) begin
      bus.ld_valid = 1; bus.ld_data = LW'(base + b);
      cyc();
    end
    bus.ld_valid = 0;
  endtask

  function automatic logic [VW-1:0] pattern(input int base);
    logic [VW-1:0] v;
    for (int l = 0; l < L; l++) v[l*LW +: LW] = LW'(base + l);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < VW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [VW-1:0] expv;
    int b;
    idle_inputs();
    bus.rd_addr_1 = '0; bus.rd_addr_2 = '0;
    rst = 1;
    reset_model();
    @(posedge clk); #1;
    check_outs();
    rst = 0;

    // All registers read back as zero and not busy.
    for (int a = 0; a < NR; a++) begin
      bus.rd_addr_1 = AW'(a); bus.rd_addr_2 = AW'(NR - 1 - a);
      cyc();
    end

    // Masked write to reg 3 with same-cycle bypass.
    bus.wr_en = 1; bus.wr_dst = 3; bus.wr_data = pattern(16'h1000); bus.wr_mask = 16'h00FF;
    bus.rd_addr_1 = 3;
    expv = '0;
    for (int l = 0; l < 8; l++) expv[l*LW +: LW] = LW'(16'h1000 + l);
    #1 chk("bypass_reg3", bus.data_1, expv);
    cyc();
    bus.wr_en = 0;
    #1 chk("stored_reg3", bus.data_1, expv);
    cyc();

    // Load to reg 5 with stalls before beats 4 and 9 and a conflicting write.
    bus.rd_addr_1 = 5; bus.rd_addr_2 = 3;
    start_load(5);
    b = 0;
    while (b < L) begin
      if (b == 4 || b == 9) begin
        bus.ld_valid = 0;
        cyc();
      end
      bus.ld_valid = 1; bus.ld_data = LW'(16'hA000 + b);
      if (b == 6) begin
        bus.wr_en = 1; bus.wr_dst = 5; bus.wr_data = rand_vec(); bus.wr_mask = 16'hFFFF;
      end
      cyc();
      bus.wr_en = 0;
      b++;
    end
    bus.ld_valid = 0;
    #1 chk("done_after_last_beat", bus.ld_done, 1'b1);
    cyc();
    #1 chk("reg5_loaded", bus.data_1, pattern(16'hA000));
    cyc();

    // Abort after 7 beats keeps reg 5; an immediate restart to reg 6 is accepted.
    start_load(5);
    beats(16'hB000, 7);
    bus.ld_abort = 1;
    cyc();
    bus.ld_abort = 0;
    #1 chk("reg5_kept_after_abort", bus.data_1, pattern(16'hA000));
    bus.rd_addr_2 = 6;
    start_load(6);
    beats(16'hC000, L);
    bus.rd_addr_1 = 2;
    bus.wr_en = 1; bus.wr_dst = 2; bus.wr_data = rand_vec(); bus.wr_mask = 16'h5A5A;
    cyc();
    bus.wr_en = 0;
    #1 chk("reg6_loaded", bus.data_2, pattern(16'hC000));
    cyc();

    // Direct write to the target in the commit cycle: loader wins.
    bus.rd_addr_1 = 4;
    start_load(4);
    beats(16'hD000, L);
    bus.wr_en = 1; bus.wr_dst = 4; bus.wr_data = rand_vec(); bus.wr_mask = 16'hFFFF;
    cyc();
    bus.wr_en = 0;
    #1 chk("reg4_loader_wins", bus.data_1, pattern(16'hD000));
    cyc();

    // Abort during the commit cycle suppresses the write.
    bus.rd_addr_1 = 1;
    start_load(1);
    beats(16'hE000, L);
    bus.ld_abort = 1;
    cyc();
    bus.ld_abort = 0;
    cyc();

    // Reset in the middle of a fill.
    bus.rd_addr_1 = 0;
    start_load(0);
    beats(16'hF000, 5);
    rst = 1;
    #1 chk("rst_drops_ld_ready", bus.ld_ready, 1'b0);
    reset_model();
    @(posedge clk); #1;
    rst = 0;
    for (int a = 0; a < NR; a++) begin
      bus.rd_addr_1 = AW'(a); bus.rd_addr_2 = AW'(a);
      cyc();
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus.wr_en     = ($urandom % 3) == 0;
      bus.wr_dst    = AW'($urandom);
      bus.wr_data   = rand_vec();
      bus.wr_mask   = L'($urandom);
      bus.ld_start  = ($urandom % 5) == 0;
      bus.ld_dst    = AW'($urandom);
      bus.ld_abort  = ($urandom % 40) == 0;
      bus.ld_valid  = ($urandom % 4) != 0;
      bus.ld_data   = LW'($urandom);
      bus.rd_addr_1 = ($urandom % 2) ? AW'(mdst) : AW'($urandom);
      bus.rd_addr_2 = AW'($urandom);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_reg_file_ls.md
Name: vector_reg_file_ls

Overview:
Parametrised successor to the vector register file. Clocked storage of NUM_REGS vectors, each LANES x LANE_W bits. Two combinational read ports with write-bypass, one full-vector write port with per-lane mask, and a lane-serial load port. The load port is a valid/ready stream that fills a staging buffer and commits it atomically, with a busy scoreboard per register. Sits between vector decode/ALU writeback and the memory load path.

Parameters:
NUM_REGS, 8, number of vector registers
LANES, 16, lanes per vector
LANE_W, 16, bits per lane
ADDR_W, 3, register address width; must equal clog2(NUM_REGS)
VEC_W, LANES*LANE_W (256), vector width; derived, not overridden

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rd_addr_1  in  ADDR_W  read port 1 register address
rd_addr_2  in  ADDR_W  read port 2 register address
data_1  out  VEC_W  read port 1 data (combinational)
data_2  out  VEC_W  read port 2 data (combinational)
busy_1  out  1  register at rd_addr_1 is being loaded
busy_2  out  1  register at rd_addr_2 is being loaded
wr_en  in  1  direct write enable
wr_dst  in  ADDR_W  direct write register address
wr_data  in  VEC_W  direct write data
wr_mask  in  LANES  per-lane write enable; bit i covers lane i
ld_start  in  1  begin lane-serial load; sampled only in IDLE
ld_dst  in  ADDR_W  load target register, sampled with ld_start
ld_abort  in  1  cancel the load in progress
ld_valid  in  1  ld_data valid
ld_data  in  LANE_W  one lane of load data
ld_ready  out  1  loader accepts a beat
ld_done  out  1  one-cycle pulse in the commit cycle
wr_conflict  out  1  registered pulse: direct write hit the busy load target

Behaviour:
- Lane i occupies bits [i*LANE_W +: LANE_W]. Lane 0 is the LSBs.
- rst (async) clears all registers, the staging buffer, busy bits and the lane counter. It forces IDLE. ld_ready, ld_done and wr_conflict go to 0. Reset mid-load discards the load; nothing is committed.
- Reads are combinational: data_n = regs[rd_addr_n].
  - Bypass: if wr_en and wr_dst == rd_addr_n, lanes with wr_mask set show wr_data. All other lanes show stored data.
  - Load commits are not bypassed.
- busy_n = busy[rd_addr_n].
- Direct write: on the clock edge with wr_en, the lanes with wr_mask set are written. wr_mask = 0 means no change.
- Loader FSM, states IDLE, FILL, COMMIT:
  - IDLE: ld_ready = 0. ld_start latches ld_dst, clears the lane counter, sets busy[ld_dst], and moves to FILL.
  - FILL: ld_ready = 1. A beat is accepted when ld_valid and ld_ready are both high. An accepted beat writes ld_data into staging lane[cnt] and increments cnt. The beat accepted at cnt == LANES-1 moves the FSM to COMMIT. ld_valid low stalls with no change.
  - COMMIT: ld_ready = 0 and ld_done = 1. The full staging vector is written to regs[dst] and busy[dst] is cleared. The FSM returns to IDLE.
  - ld_start outside IDLE is ignored. A new ld_start is accepted the cycle after COMMIT.
- Load latency: LANES accepted beats, then 1 commit cycle. A read in the cycle after ld_done returns the new vector.
- ld_abort in FILL or COMMIT: back to IDLE with busy cleared and no commit. Abort takes priority over the commit write. ld_abort in IDLE does nothing.
- Simultaneous events:
  - Direct write to the load target while busy: the write is performed, and wr_conflict pulses the next cycle. A later commit overwrites it.
  - Direct write in the COMMIT cycle to the same register: the loader wins for all lanes.
  - Direct write to a different register: both writes occur.
- wr_dst and ld_dst out of range (>= NUM_REGS, only possible when NUM_REGS is not a power of 2): the write is ignored.

Test Plan:
- Reset, then read all 8 registers -> data = 0 and busy = 0 everywhere. Assert rst mid-FILL -> ld_ready drops at once; register unchanged after release.
- wr_en, wr_dst=3, wr_data = lane i holds 16'h1000+i, wr_mask=16'h00FF, same-cycle rd_addr_1=3 -> data_1 lanes 0-7 = 1000..1007, lanes 8-15 = 0 (bypass). The next cycle shows the same stored value.
- ld_start with ld_dst=5, then 16 beats of 16'hA000+i with ld_valid deasserted on beats 4 and 9 -> ld_done pulses exactly 1 cycle after the 16th accepted beat. busy_1 for reg 5 is high from the cycle after ld_start until commit. regs[5] lane i = A000+i.
- During the load to reg 5, direct write to reg 5 with mask FFFF -> wr_conflict pulses once; after commit regs[5] holds the load data.
- ld_abort after 7 beats -> IDLE, busy cleared, regs[5] retains its old value. A new ld_start the next cycle is accepted.
- COMMIT cycle coincident with a direct write to reg 2 (load target reg 6) -> both registers are updated correctly.
